// File: rtl/cpu_run_pkg.sv
// Shared definitions for the processor run controller: state encoding,
// default widths and the halt-address helper.
package cpu_run_pkg;

  localparam int unsigned IM_DATA_W_DEF = 8;
  localparam int unsigned IM_ADDR_W_DEF = 8;
  localparam int unsigned CYC_W_DEF     = 16;
  localparam int unsigned STATE_W       = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_HALTED  = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_FAULT   = 3'd5
  } run_state_e;

  // All-ones address of the given width; callers cast to their address width.
  function automatic logic [31:0] halt_addr_default(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

  function automatic logic is_terminal(input run_state_e s);
    return (s == ST_HALTED) || (s == ST_TIMEOUT) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Program-load stream and instruction-memory write port of the run controller.
interface cpu_run_ctrl_if
  import cpu_run_pkg::*;
#(
  parameter int unsigned IM_DATA_W = IM_DATA_W_DEF,
  parameter int unsigned IM_ADDR_W = IM_ADDR_W_DEF
);

  logic                 ld_valid;
  logic                 ld_ready;
  logic [IM_DATA_W-1:0] ld_data;
  logic                 ld_last;
  logic                 im_we;
  logic [IM_ADDR_W-1:0] im_waddr;
  logic [IM_DATA_W-1:0] im_wdata;

  // Host / harness side.
  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, im_we, im_waddr, im_wdata
  );

  // Run-controller side.
  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, im_we, im_waddr, im_wdata
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads instruction memory, releases and clock-gates the core,
// and ends the run on halt address, illegal instruction, watchdog or abort.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned          IM_DATA_W = IM_DATA_W_DEF,
  parameter int unsigned          IM_ADDR_W = IM_ADDR_W_DEF,
  parameter int unsigned          CYC_W     = CYC_W_DEF,
  parameter logic [IM_ADDR_W-1:0] HALT_ADDR = IM_ADDR_W'(halt_addr_default(IM_ADDR_W))
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_run_ctrl_if.slave        bus,
  input  logic                 load_start,
  input  logic                 run_start,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic                 abort,
  input  logic                 clear,
  input  logic [CYC_W-1:0]     max_cycles,
  input  logic [IM_ADDR_W-1:0] core_pc,
  input  logic                 core_instr_ok,
  output logic                 core_en,
  output logic                 core_rst_n,
  output logic [STATE_W-1:0]   state,
  output logic [CYC_W-1:0]     cycle_count,
  output logic [IM_ADDR_W:0]   loaded_words,
  output logic                 done
);

  localparam logic [IM_ADDR_W-1:0] ADDR_MAX = '1;

  run_state_e           state_q, state_d;
  logic [IM_ADDR_W-1:0] addr_q, addr_d;
  logic [IM_ADDR_W:0]   loaded_q, loaded_d;
  logic                 im_we_q, im_we_d;
  logic [IM_ADDR_W-1:0] im_waddr_q, im_waddr_d;
  logic [IM_DATA_W-1:0] im_wdata_q, im_wdata_d;
  logic                 core_en_q, core_en_d;
  logic                 core_rst_n_q;
  logic                 done_q;
  logic                 cnt_clr;
  logic                 hs;
  logic                 wdog_hit;

  assign bus.ld_ready = (state_q == ST_LOAD);
  assign hs           = bus.ld_valid && bus.ld_ready;

  // Watchdog fires on the enabled cycle that brings the count up to the limit.
  assign wdog_hit = (max_cycles != '0) &&
                    (({1'b0, cycle_count} + (CYC_W+1)'(1)) >= {1'b0, max_cycles});

  // Next-state, load-address and core-enable decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    loaded_d   = loaded_q;
    im_we_d    = 1'b0;
    im_waddr_d = im_waddr_q;
    im_wdata_d = im_wdata_q;
    core_en_d  = 1'b0;
    cnt_clr    = 1'b0;

    if (hs) begin
      im_we_d    = 1'b1;
      im_waddr_d = addr_q;
      im_wdata_d = bus.ld_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (load_start && !abort) begin
          state_d  = ST_LOAD;
          addr_d   = '0;
          loaded_d = '0;
        end else if (run_start && !abort) begin
          state_d   = ST_RUN;
          cnt_clr   = 1'b1;
          core_en_d = !step_mode;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          loaded_d = loaded_q + (IM_ADDR_W+1)'(1);
          if (bus.ld_last || (addr_q == ADDR_MAX)) begin
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + IM_ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (core_en_q) begin
          if (!core_instr_ok) begin
            state_d = ST_FAULT;
          end else if (core_pc == HALT_ADDR) begin
            state_d = ST_HALTED;
          end else if (wdog_hit) begin
            state_d = ST_TIMEOUT;
          end
        end
        // A step seen while the core is already enabled is dropped.
        if (state_d == ST_RUN) begin
          core_en_d = step_mode ? (step && !core_en_q) : 1'b1;
        end
      end
      ST_HALTED, ST_TIMEOUT, ST_FAULT: begin
        if (clear) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      core_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      loaded_q     <= '0;
      im_we_q      <= 1'b0;
      im_waddr_q   <= '0;
      im_wdata_q   <= '0;
      core_en_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      loaded_q     <= loaded_d;
      im_we_q      <= im_we_d;
      im_waddr_q   <= im_waddr_d;
      im_wdata_q   <= im_wdata_d;
      core_en_q    <= core_en_d;
      core_rst_n_q <= (state_d != ST_IDLE) && (state_d != ST_LOAD);
      done_q       <= is_terminal(state_d);
    end
  end

  sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (core_en_q),
    .q     (cycle_count)
  );

  assign bus.im_we    = im_we_q;
  assign bus.im_waddr = im_waddr_q;
  assign bus.im_wdata = im_wdata_q;
  assign core_en      = core_en_q;
  assign core_rst_n   = core_rst_n_q;
  assign state        = state_q;
  assign loaded_words = loaded_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl: load, free-run halt,
// watchdog, single-step with fault, abort and asynchronous reset.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, run_start, step_mode, step, abort, clear;
  logic [15:0] max_cycles;
  logic [7:0]  core_pc;
  logic        core_instr_ok;
  logic        core_en, core_rst_n, done;
  logic [2:0]  state;
  logic [15:0] cycle_count;
  logic [8:0]  loaded_words;

  int n_cmp = 0;
  int n_err = 0;

  cpu_run_ctrl_if #(.IM_DATA_W(8), .IM_ADDR_W(8)) bus ();

  cpu_run_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .load_start    (load_start),
    .run_start     (run_start),
    .step_mode     (step_mode),
    .step          (step),
    .abort         (abort),
    .clear         (clear),
    .max_cycles    (max_cycles),
    .core_pc       (core_pc),
    .core_instr_ok (core_instr_ok),
    .core_en       (core_en),
    .core_rst_n    (core_rst_n),
    .state         (state),
    .cycle_count   (cycle_count),
    .loaded_words  (loaded_words),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Write log, enabled-cycle tally and a toy core whose PC counts enabled cycles.
  logic [7:0] wq_addr[$];
  logic [7:0] wq_data[$];
  int         en_total = 0;
  logic [7:0] en_cnt;
  logic       halt_mode;

  always @(posedge clk) begin
    if (bus.im_we) begin
      wq_addr.push_back(bus.im_waddr);
      wq_data.push_back(bus.im_wdata);
    end
    if (core_en) en_total <= en_total + 1;
    if (!core_rst_n) en_cnt <= 8'd0;
    else if (core_en) en_cnt <= en_cnt + 8'd1;
  end

  assign core_pc = (halt_mode && en_cnt == 8'd9) ? 8'hFF : en_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  int base;
  int en0;

  initial begin
    rst_n = 1'b0;
    load_start = 0; run_start = 0; step_mode = 0; step = 0; abort = 0; clear = 0;
    max_cycles = 16'd0; core_instr_ok = 1'b1; halt_mode = 1'b0;
    bus.ld_valid = 0; bus.ld_data = 8'h00; bus.ld_last = 0;
    tick(); tick();

    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_im_we", 32'(bus.im_we), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_cycle_count", 32'(cycle_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Five-word load ending on ld_last.
    base = wq_addr.size();
    load_start = 1; tick(); load_start = 0;
    chk("load_state", 32'(state), 32'd1);
    chk("load_ready", 32'(bus.ld_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'h11 + 8'(i);
      bus.ld_last  = (i == 4);
      tick();
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("load5_exit_state", 32'(state), 32'd0);
    chk("load5_exit_ready", 32'(bus.ld_ready), 32'd0);
    tick();
    chk("load5_nwrites", 32'(wq_addr.size() - base), 32'd5);
    chk("load5_addr0", 32'(wq_addr[base]), 32'd0);
    chk("load5_data0", 32'(wq_data[base]), 32'h11);
    chk("load5_addr4", 32'(wq_addr[base+4]), 32'd4);
    chk("load5_data4", 32'(wq_data[base+4]), 32'h15);
    chk("load5_words", 32'(loaded_words), 32'd5);

    // Full-depth load with no ld_last; valid held two cycles past the end.
    base = wq_addr.size();
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 258; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'(i);
      tick();
    end
    bus.ld_valid = 1'b0;
    tick();
    chk("full_nwrites", 32'(wq_addr.size() - base), 32'd256);
    chk("full_last_addr", 32'(wq_addr[wq_addr.size()-1]), 32'hFF);
    chk("full_last_data", 32'(wq_data[wq_data.size()-1]), 32'hFF);
    chk("full_words", 32'(loaded_words), 32'd256);
    chk("full_state", 32'(state), 32'd0);

    // Free run until PC hits the halt address on the 10th enabled cycle.
    halt_mode = 1'b1;
    en0 = en_total;
    run_start = 1; tick(); run_start = 0;
    chk("run_state", 32'(state), 32'd2);
    chk("run_core_en", 32'(core_en), 32'd1);
    chk("run_core_rst_n", 32'(core_rst_n), 32'd1);
    wait_done(50);
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_cycles", 32'(cycle_count), 32'd10);
    chk("halt_core_en", 32'(core_en), 32'd0);
    chk("halt_en_total", 32'(en_total - en0), 32'd10);
    chk("halt_core_rst_n", 32'(core_rst_n), 32'd1);
    tick();
    chk("halt_frozen", 32'(cycle_count), 32'd10);
    clear = 1; tick(); clear = 0;
    chk("clear_state", 32'(state), 32'd0);
    chk("clear_core_rst_n", 32'(core_rst_n), 32'd0);
    halt_mode = 1'b0;
    tick();

    // Watchdog at 4 cycles with a core that never halts.
    max_cycles = 16'd4;
    en0 = en_total;
    run_start = 1; tick(); run_start = 0;
    wait_done(50);
    chk("wdog_state", 32'(state), 32'd4);
    chk("wdog_cycles", 32'(cycle_count), 32'd4);
    chk("wdog_en_total", 32'(en_total - en0), 32'd4);
    clear = 1; tick(); clear = 0;
    max_cycles = 16'd0;
    tick();

    // Single-step: three pulses, the second held for two cycles, fault on the third.
    step_mode = 1'b1;
    en0 = en_total;
    run_start = 1; tick(); run_start = 0;
    chk("step_idle_en", 32'(core_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) core_instr_ok = 1'b0;
      step = 1'b1;
      tick();
      chk("step_pulse_en", 32'(core_en), 32'd1);
      if (k != 1) step = 1'b0;
      tick();
      step = 1'b0;
      chk("step_pulse_end", 32'(core_en), 32'd0);
      if (k == 1) chk("step2_cycles", 32'(cycle_count), 32'd2);
      repeat (3) tick();
    end
    chk("fault_state", 32'(state), 32'd5);
    chk("fault_cycles", 32'(cycle_count), 32'd3);
    chk("step_en_total", 32'(en_total - en0), 32'd3);
    chk("fault_done", 32'(done), 32'd1);
    clear = 1; tick(); clear = 0;
    step_mode = 1'b0; core_instr_ok = 1'b1;
    tick();

    // Abort mid-run.
    run_start = 1; tick(); run_start = 0;
    repeat (3) tick();
    abort = 1; tick(); abort = 0;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("abort_core_en", 32'(core_en), 32'd0);

    // Simultaneous starts favour LOAD.
    load_start = 1; run_start = 1; tick(); load_start = 0; run_start = 0;
    chk("both_start_state", 32'(state), 32'd1);

    // Asynchronous reset in the middle of a load.
    bus.ld_valid = 1'b1; bus.ld_data = 8'hA5;
    tick(); tick();
    rst_n = 1'b0;
    #2;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("arst_im_we", 32'(bus.im_we), 32'd0);
    chk("arst_im_waddr", 32'(bus.im_waddr), 32'd0);
    chk("arst_im_wdata", 32'(bus.im_wdata), 32'd0);
    chk("arst_loaded", 32'(loaded_words), 32'd0);
    chk("arst_cycles", 32'(cycle_count), 32'd0);
    bus.ld_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
